apb_slave_mem_ws: RTL and testbench

APB3 slave memory with a programmable depth, a fixed number of wait states, and error signalling on `pslverr`. It replaces the original fixed-latency scratch memory used behind the team's APB3 interconnect for bench and SoC scratch storage. It adds:
- a `pslverr` response for out-of-range accesses;
- a clean abort on a dropped `psel`;
- an optional write-protected low region.

---
 rtl/apb_slave_mem_ws.sv | 159 +++++++++++++++
 tb/tb_apb_slave_mem_ws.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem_ws.sv
// apb_slave_mem_ws: APB3 slave scratch memory with a fixed number of wait
// states and pslverr on out-of-range accesses. A dropped psel during the
// wait phase aborts the transfer cleanly, with no write and no pready.
// Optional feature: define APB_SLAVE_MEM_WPROT_EN to make words
// 0..WPROT_DEPTH-1 read-only. A write to one of them completes with pslverr.
// The memory is built from registers, so reset clears every word.
module apb_slave_mem_ws #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0,
  parameter int WPROT_DEPTH = 4
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  // Wide enough to hold WAIT_CYCLES; it never has to count past that value.
  localparam int CNT_W = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);
  // Compare addresses at 33 bits so that DEPTH = 2^ADDR_WIDTH cannot overflow.
  localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  enter_resp;
  logic                  addr_oor;
  logic                  err;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] prdata_reg;
  logic                  pready_reg;
  logic                  pslverr_reg;
  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

  // Error decode, taken from the bus during the cycle that enters RESP.
  assign addr_oor = (33'(paddr) >= DEPTH_EXT);

`ifdef APB_SLAVE_MEM_WPROT_EN
  localparam logic [32:0] WPROT_EXT = 33'(WPROT_DEPTH);
  logic wprot_hit;
  assign wprot_hit = pwrite && (33'(paddr) < WPROT_EXT);
  assign err       = addr_oor || wprot_hit;
`else
  assign err       = addr_oor;
`endif

  assign wr_en = enter_resp && pwrite && !err;

  // FSM state and wait counter registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic. An abort in WAIT takes priority over reaching the count.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (psel && penable) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = ST_RESP;
          enter_resp = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Read mux over the in-range words. An out-of-range address reads as 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (33'(paddr) == 33'(i)) begin
        rd_word = mem_reg[i];
      end
    end
  end

  // Memory array. Cleared on reset and written only on an error-free RESP entry.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (33'(paddr) == 33'(i)) begin
          mem_reg[i] <= pwdata;
        end
      end
    end
  end

  // Registered response: a one-cycle pready, pslverr qualified by pready,
  // and prdata that updates only on reads and holds its value otherwise.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
      prdata_reg  <= '0;
    end else begin
      pready_reg  <= enter_resp;
      pslverr_reg <= enter_resp && err;
      if (enter_resp && !pwrite) begin
        prdata_reg <= err ? '0 : rd_word;
      end
    end
  end

  assign pready  = pready_reg;
  assign pslverr = pslverr_reg;
  assign prdata  = prdata_reg;

endmodule

// File: tb/tb_apb_slave_mem_ws.sv
// tb_apb_slave_mem_ws: scoreboard bench for apb_slave_mem_ws (DEPTH = 12,
// WAIT_CYCLES = 3). The driver pushes the expected response for each transfer
// and the monitor pops and compares it when pready rises. The expectation for
// a write-protected word follows APB_SLAVE_MEM_WPROT_EN.
module tb_apb_slave_mem_ws;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 12;
  localparam int WAIT  = 3;
  localparam int WPROT = 4;
`ifdef APB_SLAVE_MEM_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  logic          pclk    = 1'b0;
  logic          presetn = 1'b0;
  logic          psel    = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite  = 1'b0;
  logic [AW-1:0] paddr   = '0;
  logic [DW-1:0] pwdata  = '0;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  apb_slave_mem_ws #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAIT),
    .WPROT_DEPTH(WPROT)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .psel   (psel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_txn    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    bit            err;
    int            t0;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_prdata;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_prdata = '0;
  endtask

  // Monitor: pop one expectation per pready pulse and compare.
  exp_t mon_e;
  logic pready_prev = 1'b0;
  always @(negedge pclk) begin
    if (presetn && pready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pready", pready, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        n_txn++;
        check("latency", 64'(cyc - mon_e.t0), 64'(1 + WAIT));
        check("pready_one_cycle", pready_prev, 1'b0);
        check("pslverr", pslverr, mon_e.err);
        check("prdata", prdata, mon_e.rdata);
        $display("txn %0d: %s addr=%0d prdata=0x%08h pslverr=%0b latency=%0d",
                 n_txn, mon_e.wr ? "wr" : "rd", mon_e.addr, prdata, pslverr, cyc - mon_e.t0);
      end
    end
    pready_prev = pready;
  end

  // One complete APB transfer. The expected response is computed from the model.
  task automatic xfer(input bit wr, input int addr, input logic [DW-1:0] data);
    exp_t e;
    bit   err;
    bit   got;
    err = (addr >= DEPTH) || (WPROT_ON && wr && (addr < WPROT));
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = AW'(addr); pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    if (!wr) model_prdata = err ? '0 : model_mem[addr];
    else if (!err) model_mem[addr] = data;
    e.wr = wr; e.addr = AW'(addr); e.rdata = model_prdata; e.err = err; e.t0 = cyc;
    sb_q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge pclk);
      got = pready;
    end
    check("ready_timeout", got, 1'b1);
    if (!got) sb_q.delete();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    check("pready_low_after", pready, 1'b0);
    check("pslverr_low_after", pslverr, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    model_reset();
    // Reset state.
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_pready", pready, 1'b0);
    check("rst_pslverr", pslverr, 1'b0);
    check("rst_prdata", prdata, '0);
    presetn = 1'b1;

    // A read right after reset returns 0.
    xfer(1'b0, 5, '0);

    // Abort: a write to addr 2 with psel dropped at T0+2.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(2); pwdata = 32'hAA;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pclk);
      if (pready) seen++;
    end
    check("abort_no_pready", 64'(seen), 64'(0));
    xfer(1'b0, 2, '0);

    // Write then read back with wait states.
    xfer(1'b1, 9, 32'hDEADBEEF);
    xfer(1'b0, 9, '0);

    // Out of range: a write is dropped and a read returns 0 with pslverr.
    xfer(1'b1, 13, 32'h1234);
    xfer(1'b0, 13, '0);
    xfer(1'b0, 12, '0);
    xfer(1'b1, 11, 32'hCAFE0011);
    xfer(1'b0, 11, '0);

    // Low region: protected only when the macro is defined.
    xfer(1'b1, 3, 32'h55);
    xfer(1'b0, 3, '0);
    xfer(1'b1, 4, 32'h55);
    xfer(1'b0, 4, '0);

    // Confirm that no word changed unexpectedly.
    for (int a = 0; a < DEPTH; a++) xfer(1'b0, a, '0);

    // Reset mid-wait: outputs clear at once and the memory is wiped.
    xfer(1'b0, 9, '0);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = AW'(9);
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    check("midrst_pready", pready, 1'b0);
    check("midrst_pslverr", pslverr, 1'b0);
    check("midrst_prdata", prdata, '0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    model_reset();
    xfer(1'b0, 9, '0);
    xfer(1'b0, 4, '0);

    // Random mix that includes out-of-range addresses.
    for (int i = 0; i < 12; i++) begin
      xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 13)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
